// File: rtl/ads1256_spi_responder.sv
// ADS1256-style SPI peripheral emulator (CPOL=0, CPHA=1) with DRDY strobe.
// Build option ADS_RESP_LOOPBACK_EN: MISO replays the previous rx_data instead of the hold register.
`timescale 1ns/1ps
module ads1256_spi_responder #(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_drdy_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  // state | meaning
  // IDLE  | waiting for an SCLK rise with cs_n low; MISO held low
  // SHIFT | frame in flight; MOSI sampled on falls, MISO advanced on rises
  // DONE  | single cycle publishing rx_data and rx_valid
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic sclk_dly, cs_dly, mosi_smp;
  logic sclk_rise, sclk_fall, cs_rise;

  logic [DATA_W-1:0] hold;
  logic [DATA_W-2:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_src;
  logic [CNT_W-1:0]  bit_cnt;
  logic              pending;
  logic              start, abort, last_fall;

  // Edge pulses are registered, so cs_dly and mosi_smp line up with them.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_dly  <= 1'b0;
      cs_dly    <= 1'b1;
      mosi_smp  <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
      cs_dly    <= cs_sync[SYNC_STAGES-1];
      mosi_smp  <= mosi_sync[SYNC_STAGES-1];
      sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_dly;
      sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_dly;
      cs_rise   <= cs_sync[SYNC_STAGES-1] & ~cs_dly;
    end
  end

`ifdef ADS_RESP_LOOPBACK_EN
  assign tx_src = rx_data;
`else
  assign tx_src = hold;
`endif

  assign spi_drdy_n = ~pending;
  assign last_fall  = sclk_fall && (bit_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (sclk_rise && !cs_dly) begin
          start     = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (last_fall) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      pending   <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      spi_miso  <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // A load in the frame-start cycle wins: the frame takes the old hold value.
      if (tx_load) begin
        hold    <= tx_data;
        pending <= 1'b1;
      end else if (start) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          spi_miso <= 1'b0;
          if (start) begin
            tx_shift <= tx_src[DATA_W-2:0];
            spi_miso <= tx_src[DATA_W-1];
            rx_shift <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            frame_err <= 1'b1;
            spi_miso  <= 1'b0;
          end else begin
            if (sclk_fall) begin
              rx_shift <= {rx_shift[DATA_W-2:0], mosi_smp};
              bit_cnt  <= bit_cnt + 1'b1;
            end
            if (sclk_rise) begin
              spi_miso <= tx_shift[DATA_W-2];
              tx_shift <= {tx_shift[DATA_W-3:0], 1'b0};
            end
          end
        end
        DONE: begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
          spi_miso <= 1'b0;
        end
        default: spi_miso <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ads1256_spi_responder.sv
// Self-checking bench for ads1256_spi_responder: vector table of frames, hand-written
// corner sequences, and an rx_data scoreboard fed when each full frame is driven.
`timescale 1ns/1ps
module tb_ads1256_spi_responder;
  localparam int W    = 24;
  localparam int HALF = 10;

  logic         sys_clk  = 1'b0;
  logic         rst_n    = 1'b1;
  logic         spi_sclk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         tx_load  = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         spi_miso, spi_drdy_n, rx_valid, frame_err;
  logic [W-1:0] rx_data;

  int n_vec  = 0;
  int n_err  = 0;
  int n_rxv  = 0;
  int n_ferr = 0;
  logic [W-1:0] exp_q[$];
  logic drdy_first, drdy_hook;
  logic rxv_d = 1'b0;

  typedef struct {
    logic         do_load;
    logic [W-1:0] load_v;
    logic [W-1:0] mosi;
    logic [W-1:0] exp_miso;
    logic         exp_drdy_before;
    logic         exp_drdy_first;
  } vec_t;
  vec_t vecs[4];

  always #5 sys_clk = ~sys_clk;

  ads1256_spi_responder #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_drdy_n(spi_drdy_n),
    .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  always @(negedge sys_clk) begin
    if (rx_valid) begin
      n_rxv++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data %h, expected none", rx_data);
      end else begin
        chk("rx_data", rx_data, exp_q.pop_front());
      end
    end
    if (rx_valid && rxv_d) begin
      n_vec++;
      n_err++;
      $display("FAIL rx_valid_width: got 2+ cycles, expected 1");
    end
    rxv_d = rx_valid;
    if (frame_err) n_ferr++;
  end

  task automatic load(input logic [W-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    wait_cyc(1);
    tx_load = 1'b0;
  endtask

  // hook_kind: 0 none, 1 tx_load of hook_v, 2 reset pulse; applied while SCLK is high on hook_bit.
  task automatic frame(input logic [W-1:0] mosi_w, input int nbits, input int hook_bit,
                       input int hook_kind, input logic [W-1:0] hook_v, input bit cs_tied,
                       output logic [W-1:0] miso_w);
    miso_w = '0;
    if (nbits == W) exp_q.push_back(mosi_w);
    if (!cs_tied) begin
      spi_cs_n = 1'b0;
      wait_cyc(HALF);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b1;
      spi_mosi = mosi_w[W-1-i];
      wait_cyc(HALF - 4);
      if (i == 0) drdy_first = spi_drdy_n;
      if (i == hook_bit && hook_kind == 1) begin
        tx_data = hook_v;
        tx_load = 1'b1;
        wait_cyc(1);
        tx_load = 1'b0;
        drdy_hook = spi_drdy_n;
        wait_cyc(1);
      end else if (i == hook_bit && hook_kind == 2) begin
        rst_n = 1'b0;
        #2;
        chk("rst_mid_miso", W'(spi_miso), '0);
        chk("rst_mid_drdy", W'(spi_drdy_n), W'(1'b1));
        chk("rst_mid_rx_data", rx_data, '0);
        chk("rst_mid_rx_valid", W'(rx_valid), '0);
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(1);
      end else begin
        wait_cyc(2);
      end
      wait_cyc(2);
      miso_w[W-1-i] = spi_miso;
      spi_sclk = 1'b0;
      wait_cyc(HALF);
    end
    if (!cs_tied) begin
      spi_cs_n = 1'b1;
      wait_cyc(HALF);
    end
  endtask

  initial begin
    logic [W-1:0] got;
    logic [W-1:0] tied_mosi[3];
    logic [W-1:0] tied_exp[3];
    int ferr0, rxv0;

`ifdef ADS_RESP_LOOPBACK_EN
    vecs[0] = '{1'b1, 24'hA5C3F0, 24'h123456, 24'h000000, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 24'h000000, 24'h0F0F0F, 24'h123456, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 24'h5A5A5A, 24'hFFFFFF, 24'h0F0F0F, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 24'h000000, 24'h000001, 24'hFFFFFF, 1'b1, 1'b1};
`else
    vecs[0] = '{1'b1, 24'hA5C3F0, 24'h123456, 24'hA5C3F0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 24'h000000, 24'h0F0F0F, 24'hA5C3F0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 24'h5A5A5A, 24'hFFFFFF, 24'h5A5A5A, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 24'h000000, 24'h000001, 24'h5A5A5A, 1'b1, 1'b1};
`endif

    #2 rst_n = 1'b0;
    wait_cyc(3);
    chk("reset_miso", W'(spi_miso), '0);
    chk("reset_drdy", W'(spi_drdy_n), W'(1'b1));
    chk("reset_rx_data", rx_data, '0);
    chk("reset_rx_valid", W'(rx_valid), '0);
    chk("reset_frame_err", W'(frame_err), '0);
    rst_n = 1'b1;
    wait_cyc(3);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].do_load) load(vecs[v].load_v);
      chk("drdy_before", W'(spi_drdy_n), W'(vecs[v].exp_drdy_before));
      frame(vecs[v].mosi, W, -1, 0, '0, 1'b0, got);
      chk("miso_word", got, vecs[v].exp_miso);
      chk("drdy_after_first_sclk", W'(drdy_first), W'(vecs[v].exp_drdy_first));
    end

    // Abort after 10 SCLKs, then a clean frame.
    ferr0 = n_ferr;
    rxv0  = n_rxv;
    frame(24'h3C3C3C, 10, -1, 0, '0, 1'b0, got);
    chk("abort_frame_err", W'(n_ferr - ferr0), W'(1));
    chk("abort_no_rx_valid", W'(n_rxv - rxv0), '0);
    chk("abort_rx_kept", rx_data, 24'h000001);
    chk("abort_drdy", W'(spi_drdy_n), W'(1'b1));
    frame(24'h00FF00, W, -1, 0, '0, 1'b0, got);
`ifdef ADS_RESP_LOOPBACK_EN
    chk("post_abort_miso", got, 24'h000001);
`else
    chk("post_abort_miso", got, 24'h5A5A5A);
`endif
    chk("post_abort_rx_data", rx_data, 24'h00FF00);

    // Newest load wins; a load mid-frame leaves the frame alone.
    load(24'h111111);
    load(24'h222222);
    frame(24'h765432, W, 5, 1, 24'h333333, 1'b0, got);
`ifdef ADS_RESP_LOOPBACK_EN
    chk("double_load_miso", got, 24'h00FF00);
`else
    chk("double_load_miso", got, 24'h222222);
`endif
    chk("midframe_load_drdy", W'(drdy_hook), '0);
    chk("midframe_load_drdy_end", W'(spi_drdy_n), '0);

    // cs_n tied low: three back-to-back frames.
    tied_mosi[0] = 24'hABCDEF;
    tied_mosi[1] = 24'h135790;
    tied_mosi[2] = 24'h24680A;
`ifdef ADS_RESP_LOOPBACK_EN
    tied_exp[0] = 24'h765432;
    tied_exp[1] = 24'hABCDEF;
    tied_exp[2] = 24'h135790;
`else
    tied_exp[0] = 24'h333333;
    tied_exp[1] = 24'h333333;
    tied_exp[2] = 24'h333333;
`endif
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    rxv0 = n_rxv;
    for (int f = 0; f < 3; f++) begin
      frame(tied_mosi[f], W, -1, 0, '0, 1'b1, got);
      chk("tied_miso", got, tied_exp[f]);
    end
    wait_cyc(HALF);
    chk("tied_rx_valid_count", W'(n_rxv - rxv0), W'(3));
    chk("tied_rx_data", rx_data, 24'h24680A);
    spi_cs_n = 1'b1;
    wait_cyc(HALF);

    // Reset mid-frame while MISO is high, then a fresh frame.
    load(24'hFFFFFF);
    frame(24'h000000, 10, 5, 2, '0, 1'b0, got);
    chk("post_reset_rx_data", rx_data, '0);
    chk("post_reset_drdy", W'(spi_drdy_n), W'(1'b1));
    frame(24'hC0FFEE, W, -1, 0, '0, 1'b0, got);
    chk("post_reset_miso", got, '0);

    wait_cyc(20);
    chk("scoreboard_drained", W'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
